dnn_param_store: RTL and testbench
==================================

// Module: dnn_param_store
// PURPOSE
//  Runtime-loadable, double-buffered weight/bias store for the 2-layer MLP engine (N_IN -> N_HID -> N_OUT).
//  Replaces fixed constant parameter tables: parameters stream in over a valid/ready port into a shadow bank.
//  A complete, error-free load swaps the shadow bank to active. The compute engine reads active values through a registered read port.
//  The compute engine may run uninterrupted on the old bank while a reload is in progress.
// PARAMETERS
//  N_IN   4   layer-1 inputs
//  N_HID  3   hidden neurons
//  N_OUT  2   outputs
//  W_W    8   weight width, signed two's complement
//  B_W    16  bias width and stream/read data width, signed; B_W >= W_W
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  load_start    in   1      pulse: begin a new load into the shadow bank
//  ld_valid      in   1      stream word valid
//  ld_ready      out  1      store accepts a word; accept = ld_valid & ld_ready
//  ld_data       in   B_W    stream word; weights are sent sign-extended, and the store keeps [W_W-1:0]
//  ld_last       in   1      marks the final word of a load
//  load_busy     out  1      load in progress
//  load_err      out  1      sticky framing/checksum error; cleared by load_start
//  params_valid  out  1      active bank holds a completed load
//  swap_pulse    out  1      one-cycle pulse when the active bank changes
//  rd_sel        in   2      region: 0=W1, 1=W2, 2=B1, 3=B2
//  rd_addr       in   AW     element index; AW = clog2(max(N_IN*N_HID, N_HID*N_OUT))
//  rd_data       out  B_W    active-bank value, sign-extended; 1-cycle latency
// BEHAVIOUR
//  Reset values: both banks 0, bank_sel=0, FSM=IDLE.
//  Reset output values: ld_ready=0, load_busy=0, load_err=0, params_valid=0, swap_pulse=0, rd_data=0.
//  Stream order:
//   - W1: N_IN*N_HID words, index i*N_HID+j (input i, neuron j).
//   - W2: N_HID*N_OUT words, index h*N_OUT+o.
//   - B1: N_HID words, then B2: N_OUT words.
//   - TOTAL = 23 words at default parameters.
//  FSM states: IDLE, LD_W1, LD_W2, LD_B1, LD_B2, (LD_CSUM), ERR.
//   - IDLE/ERR -> LD_W1 on load_start; load_start also clears load_err and the word counter.
//   - LD_x -> next region when the region counter wraps at its size.
//   - Final word accepted with ld_last=1 -> IDLE. Bank_sel toggles, swap_pulse=1 and params_valid=1 on the next edge.
//   - ld_last=1 on any earlier word -> ERR; the word is not written.
//   - Final word accepted with ld_last=0 -> ERR.
//   - ERR: load_err=1, no swap, active bank and params_valid unchanged.
//  ld_ready=1 only in LD_* states. load_busy=1 in LD_* states.
//  load_start while busy: ignored. ld_valid in IDLE/ERR: ignored.
//  Read timing: rd_data is registered from the active bank.
//   - Read presented in the cycle the final word is accepted: returns old bank data.
//   - Read presented in the following cycle: returns new bank data.
//   - Out-of-range rd_addr for the region returns 0.
//  Reset asserted mid-load: load abandoned, everything returns to reset values.
// CONFIGURATION
//  PARAM_CHECKSUM_EN defined:
//   - One extra trailing word (state LD_CSUM) follows B2 and carries ld_last.
//   - The checksum word must equal the mod-2^B_W sum of all preceding B_W-bit words as sent.
//   - Match -> swap. Mismatch -> ERR, no swap.
//   - ld_last on the B2 final word -> ERR.
//  PARAM_CHECKSUM_EN undefined: no LD_CSUM state, no adder; the B2 final word carries ld_last.
// STRUCTURE
//  dnn_param_pkg:
//   - region enum (W1/W2/B1/B2).
//   - FSM state enum.
//   - size functions: n_w1 = N_IN*N_HID, n_w2 = N_HID*N_OUT, TOTAL, AW.
//  Sub-module dnn_param_bank: one bank with four register arrays, one write port (region, addr, data), and a combinational read mux.
//   - Instantiated twice.
//   - Top holds FSM, counters, bank_sel, checksum logic and the rd_data register.
// TESTING
//  1. Load 23 default words (W1 26,58,-2,22,15,-40,1,-53,27,-59,-16,-61; W2 63,44,13,36,-1,-15; B1 5,-2,-42; B2 59,-47), last on word 23.
//     -> swap_pulse once, params_valid=1.
//     -> rd W1[2]=16'hFFFE, W2[4]=16'hFFFF, B1[2]=16'hFFD6, B2[0]=16'h003B.
//  2. After test 1, reload with all words=7 and ld_last on word 10 -> load_err=1, no swap_pulse, rd W1[0] still 16'h001A.
//  3. Reload with all words=7 while reading B2[1] every cycle.
//     -> reads return 16'hFFD1 until the cycle after the final accept, then 16'h0007.
//  4. Drive ld_valid with a 1-on/1-off pattern during a load.
//     -> exactly 23 accepts, counters hold while ld_valid=0.
//     -> load_start pulsed mid-load is ignored.
//  5. Assert rst_n=0 after 5 accepted words.
//     -> ld_ready=0, params_valid=0, rd_data=0 next cycle; a new full load afterwards succeeds.
//  6. PARAM_CHECKSUM_EN: test-1 data + checksum 16'h001F -> swap.
//     Same data + checksum 16'h0020 -> load_err=1, active bank unchanged.

Source files
------------

// File: rtl/dnn_param_pkg.sv
// Shared types, FSM encodings and size helpers for the MLP parameter store.
// PARAM_CHECKSUM_EN adds the trailing checksum state encoding.
package dnn_param_pkg;

    typedef enum logic [1:0] {
        RegW1 = 2'd0,
        RegW2 = 2'd1,
        RegB1 = 2'd2,
        RegB2 = 2'd3
    } region_e;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLdW1   = 3'd1;
    localparam logic [2:0] StLdW2   = 3'd2;
    localparam logic [2:0] StLdB1   = 3'd3;
    localparam logic [2:0] StLdB2   = 3'd4;
`ifdef PARAM_CHECKSUM_EN
    localparam logic [2:0] StLdCsum = 3'd5;
`endif
    localparam logic [2:0] StErr    = 3'd6;

    function automatic int unsigned n_w1(input int unsigned n_in, input int unsigned n_hid);
        return n_in * n_hid;
    endfunction

    function automatic int unsigned n_w2(input int unsigned n_hid, input int unsigned n_out);
        return n_hid * n_out;
    endfunction

    function automatic int unsigned total(input int unsigned n_in, input int unsigned n_hid,
                                          input int unsigned n_out);
        return n_w1(n_in, n_hid) + n_w2(n_hid, n_out) + n_hid + n_out;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned addr_w(input int unsigned n_in, input int unsigned n_hid,
                                           input int unsigned n_out);
        int unsigned a;
        int unsigned b;
        a = n_w1(n_in, n_hid);
        b = n_w2(n_hid, n_out);
        return idx_w((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/dnn_param_bank.sv
// One parameter bank: W1/W2/B1/B2 register arrays, a single write port and
// a combinational sign-extending read mux (out-of-range reads return 0).
module dnn_param_bank
    import dnn_param_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_HID = 3,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned W_W   = 8,
    parameter int unsigned B_W   = 16,
    parameter int unsigned AW    = addr_w(N_IN, N_HID, N_OUT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  region_e        wr_region,
    input  logic [AW-1:0]  wr_addr,
    input  logic [B_W-1:0] wr_data,
    input  region_e        rd_region,
    input  logic [AW-1:0]  rd_addr,
    output logic [B_W-1:0] rd_val
);

    localparam int unsigned NW1 = n_w1(N_IN, N_HID);
    localparam int unsigned NW2 = n_w2(N_HID, N_OUT);
    localparam int unsigned IW1 = idx_w(NW1);
    localparam int unsigned IW2 = idx_w(NW2);
    localparam int unsigned IB1 = idx_w(N_HID);
    localparam int unsigned IB2 = idx_w(N_OUT);

    logic [W_W-1:0] w1_q [NW1];
    logic [W_W-1:0] w2_q [NW2];
    logic [B_W-1:0] b1_q [N_HID];
    logic [B_W-1:0] b2_q [N_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW1; i++) w1_q[i] <= '0;
            for (int i = 0; i < NW2; i++) w2_q[i] <= '0;
            for (int i = 0; i < N_HID; i++) b1_q[i] <= '0;
            for (int i = 0; i < N_OUT; i++) b2_q[i] <= '0;
        end else if (we) begin
            case (wr_region)
                RegW1: if (32'(wr_addr) < NW1) w1_q[wr_addr[IW1-1:0]] <= wr_data[W_W-1:0];
                RegW2: if (32'(wr_addr) < NW2) w2_q[wr_addr[IW2-1:0]] <= wr_data[W_W-1:0];
                RegB1: if (32'(wr_addr) < N_HID) b1_q[wr_addr[IB1-1:0]] <= wr_data;
                RegB2: if (32'(wr_addr) < N_OUT) b2_q[wr_addr[IB2-1:0]] <= wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (rd_region)
            RegW1: if (32'(rd_addr) < NW1) rd_val = B_W'($signed(w1_q[rd_addr[IW1-1:0]]));
            RegW2: if (32'(rd_addr) < NW2) rd_val = B_W'($signed(w2_q[rd_addr[IW2-1:0]]));
            RegB1: if (32'(rd_addr) < N_HID) rd_val = b1_q[rd_addr[IB1-1:0]];
            RegB2: if (32'(rd_addr) < N_OUT) rd_val = b2_q[rd_addr[IB2-1:0]];
            default: ;
        endcase
    end

endmodule

// File: rtl/dnn_param_store.sv
// Double-buffered, stream-loaded weight/bias store for the 2-layer MLP engine.
// Define PARAM_CHECKSUM_EN to require a trailing mod-2^B_W checksum word.
module dnn_param_store
    import dnn_param_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_HID = 3,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned W_W   = 8,
    parameter int unsigned B_W   = 16,
    localparam int unsigned AW   = addr_w(N_IN, N_HID, N_OUT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_start,
    input  logic           ld_valid,
    output logic           ld_ready,
    input  logic [B_W-1:0] ld_data,
    input  logic           ld_last,
    output logic           load_busy,
    output logic           load_err,
    output logic           params_valid,
    output logic           swap_pulse,
    input  logic [1:0]     rd_sel,
    input  logic [AW-1:0]  rd_addr,
    output logic [B_W-1:0] rd_data
);

    localparam int unsigned NW1 = n_w1(N_IN, N_HID);
    localparam int unsigned NW2 = n_w2(N_HID, N_OUT);

    logic [2:0]     state_q, state_d, next_ld;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           bank_sel_q, bank_sel_d;
    logic           params_valid_q, params_valid_d;
    logic           swap_q, swap_d;
    logic [B_W-1:0] rd_data_q;
`ifdef PARAM_CHECKSUM_EN
    logic [B_W-1:0] sum_q, sum_d;
`endif

    logic           in_load, accept, cnt_wrap, is_final, we, swap_req;
    region_e        region;
    int unsigned    region_size;
    logic [B_W-1:0] rd_val0, rd_val1;

    always_comb begin
        in_load     = 1'b0;
        region      = RegW1;
        region_size = NW1;
        next_ld     = StIdle;
        case (state_q)
            StLdW1: begin in_load = 1'b1; region = RegW1; region_size = NW1;   next_ld = StLdW2; end
            StLdW2: begin in_load = 1'b1; region = RegW2; region_size = NW2;   next_ld = StLdB1; end
            StLdB1: begin in_load = 1'b1; region = RegB1; region_size = N_HID; next_ld = StLdB2; end
            StLdB2: begin
                in_load     = 1'b1;
                region      = RegB2;
                region_size = N_OUT;
`ifdef PARAM_CHECKSUM_EN
                next_ld     = StLdCsum;
`endif
            end
`ifdef PARAM_CHECKSUM_EN
            StLdCsum: in_load = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept   = ld_valid & in_load;
    assign cnt_wrap = (32'(cnt_q) == region_size - 1);
`ifdef PARAM_CHECKSUM_EN
    assign is_final = 1'b0;
`else
    assign is_final = (state_q == StLdB2) && cnt_wrap;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bank_sel_d     = bank_sel_q;
        params_valid_d = params_valid_q;
        swap_d         = 1'b0;
        we             = 1'b0;
        swap_req       = 1'b0;
`ifdef PARAM_CHECKSUM_EN
        sum_d          = sum_q;
`endif
        case (state_q)
            StIdle, StErr: begin
                if (load_start) begin
                    state_d = StLdW1;
                    cnt_d   = '0;
`ifdef PARAM_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLdW1, StLdW2, StLdB1, StLdB2: begin
                if (accept) begin
                    // ld_last must coincide exactly with the final data word
                    if (ld_last != is_final) begin
                        state_d = StErr;
                    end else begin
                        we = 1'b1;
`ifdef PARAM_CHECKSUM_EN
                        sum_d = sum_q + ld_data;
`endif
                        if (is_final) begin
                            state_d  = StIdle;
                            cnt_d    = '0;
                            swap_req = 1'b1;
                        end else if (cnt_wrap) begin
                            state_d = next_ld;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                end
            end
`ifdef PARAM_CHECKSUM_EN
            StLdCsum: begin
                if (accept) begin
                    if (ld_last && (ld_data == sum_q)) begin
                        state_d  = StIdle;
                        swap_req = 1'b1;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        if (swap_req) begin
            bank_sel_d     = ~bank_sel_q;
            params_valid_d = 1'b1;
            swap_d         = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bank_sel_q     <= 1'b0;
            params_valid_q <= 1'b0;
            swap_q         <= 1'b0;
            rd_data_q      <= '0;
`ifdef PARAM_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bank_sel_q     <= bank_sel_d;
            params_valid_q <= params_valid_d;
            swap_q         <= swap_d;
            rd_data_q      <= bank_sel_q ? rd_val1 : rd_val0;
`ifdef PARAM_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    // Loads always target the bank that is not currently active
    dnn_param_bank #(
        .N_IN (N_IN),
        .N_HID(N_HID),
        .N_OUT(N_OUT),
        .W_W  (W_W),
        .B_W  (B_W),
        .AW   (AW)
    ) u_bank0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we & bank_sel_q),
        .wr_region(region),
        .wr_addr  (cnt_q),
        .wr_data  (ld_data),
        .rd_region(region_e'(rd_sel)),
        .rd_addr  (rd_addr),
        .rd_val   (rd_val0)
    );

    dnn_param_bank #(
        .N_IN (N_IN),
        .N_HID(N_HID),
        .N_OUT(N_OUT),
        .W_W  (W_W),
        .B_W  (B_W),
        .AW   (AW)
    ) u_bank1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we & ~bank_sel_q),
        .wr_region(region),
        .wr_addr  (cnt_q),
        .wr_data  (ld_data),
        .rd_region(region_e'(rd_sel)),
        .rd_addr  (rd_addr),
        .rd_val   (rd_val1)
    );

    assign ld_ready     = in_load;
    assign load_busy    = in_load;
    assign load_err     = (state_q == StErr);
    assign params_valid = params_valid_q;
    assign swap_pulse   = swap_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_dnn_param_store.sv
// Directed self-checking bench for dnn_param_store; covers the checksum
// variant when PARAM_CHECKSUM_EN is defined.
module tb_dnn_param_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        load_busy;
    logic        load_err;
    logic        params_valid;
    logic        swap_pulse;
    logic [1:0]  rd_sel;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int swap_cnt = 0;

    int v1 [23] = '{26, 58, -2, 22, 15, -40, 1, -53, 27, -59, -16, -61,
                    63, 44, 13, 36, -1, -15, 5, -2, -42, 59, -47};
    int v4 [23];
    int v7 [23];

    dnn_param_store dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .load_busy   (load_busy),
        .load_err    (load_err),
        .params_valid(params_valid),
        .swap_pulse  (swap_pulse),
        .rd_sel      (rd_sel),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_valid && ld_ready) acc_cnt <= acc_cnt + 1;
        if (swap_pulse) swap_cnt <= swap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] exp,
                      input string tag);
        rd_sel  = sel;
        rd_addr = addr;
        step();
        check(tag, rd_data, exp);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send(input int d, input logic last);
        ld_data  = 16'(d);
        ld_last  = last;
        ld_valid = 1'b1;
        for (int k = 0; k < 20 && !ld_ready; k++) step();
        if (!ld_ready) check("ld_ready_timeout", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // csum < 0 sends the correct checksum (checksum build only)
    task automatic full_load(input int v[23], input int gap, input logic mid_start, input int csum);
        logic [15:0] sum;
        sum = '0;
        start_load();
        for (int i = 0; i < 23; i++) begin
`ifdef PARAM_CHECKSUM_EN
            send(v[i], 1'b0);
`else
            send(v[i], i == 22);
`endif
            sum = sum + 16'(v[i]);
            if (mid_start && i == 10) start_load();
            repeat (gap) step();
        end
`ifdef PARAM_CHECKSUM_EN
        send((csum < 0) ? int'(sum) : csum, 1'b1);
`else
        if (csum > 0) sum = '0;
`endif
    endtask

    initial begin
        int s0;
        int a0;
        for (int i = 0; i < 23; i++) begin
            v4[i] = i + 1;
            v7[i] = 7;
        end
        rst_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_data = '0; rd_sel = 2'd0; rd_addr = '0;
        step(); step();
        check("rst_ld_ready", ld_ready, 0);
        check("rst_busy", load_busy, 0);
        check("rst_err", load_err, 0);
        check("rst_pvalid", params_valid, 0);
        check("rst_swap", swap_pulse, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        step();

        // Test 1: default load
        s0 = swap_cnt;
        full_load(v1, 0, 1'b0, -1);
        check("t1_swap_pulse", swap_pulse, 1);
        check("t1_pvalid", params_valid, 1);
        check("t1_busy", load_busy, 0);
        check("t1_err", load_err, 0);
        step();
        check("t1_swap_low", swap_pulse, 0);
        check("t1_swap_cnt", swap_cnt - s0, 1);
        rd(2'd0, 4'd2, 16'hFFFE, "t1_w1_2");
        rd(2'd1, 4'd4, 16'hFFFF, "t1_w2_4");
        rd(2'd2, 4'd2, 16'hFFD6, "t1_b1_2");
        rd(2'd3, 4'd0, 16'h003B, "t1_b2_0");
        rd(2'd3, 4'd5, 16'h0000, "oor_b2_5");
        rd(2'd1, 4'd9, 16'h0000, "oor_w2_9");
        rd(2'd2, 4'd3, 16'h0000, "oor_b1_3");

        // Test 2: early ld_last
        s0 = swap_cnt;
        start_load();
        check("t2_busy", load_busy, 1);
        for (int i = 0; i < 10; i++) send(7, i == 9);
        step();
        check("t2_err", load_err, 1);
        check("t2_ready", ld_ready, 0);
        check("t2_pvalid", params_valid, 1);
        check("t2_no_swap", swap_cnt - s0, 0);
        rd(2'd0, 4'd0, 16'h001A, "t2_w1_0");

        // Test 3: read active bank throughout a reload
        rd_sel = 2'd3; rd_addr = 4'd1;
        start_load();
        check("t3_err_clear", load_err, 0);
        for (int i = 0; i < 23; i++) begin
`ifdef PARAM_CHECKSUM_EN
            send(7, 1'b0);
`else
            send(7, i == 22);
`endif
            check("t3_old", rd_data, 16'hFFD1);
        end
`ifdef PARAM_CHECKSUM_EN
        send(161, 1'b1);
        check("t3_old_csum", rd_data, 16'hFFD1);
`endif
        step();
        check("t3_new", rd_data, 16'h0007);

        // Test 4: gapped stream with an ignored mid-load start
        a0 = acc_cnt;
        s0 = swap_cnt;
        full_load(v4, 1, 1'b1, -1);
        step();
`ifdef PARAM_CHECKSUM_EN
        check("t4_accepts", acc_cnt - a0, 24);
`else
        check("t4_accepts", acc_cnt - a0, 23);
`endif
        check("t4_swap_cnt", swap_cnt - s0, 1);
        check("t4_err", load_err, 0);
        rd(2'd0, 4'd11, 16'h000C, "t4_w1_11");
        rd(2'd1, 4'd0, 16'h000D, "t4_w2_0");
        rd(2'd3, 4'd1, 16'h0017, "t4_b2_1");

`ifdef PARAM_CHECKSUM_EN
        // Test 6: checksum mismatch, ld_last on B2, then a good checksum
        s0 = swap_cnt;
        full_load(v1, 0, 1'b0, 32'h20);
        step();
        check("t6_bad_err", load_err, 1);
        check("t6_bad_no_swap", swap_cnt - s0, 0);
        rd(2'd0, 4'd0, 16'h0001, "t6_bad_w1_0");
        start_load();
        for (int i = 0; i < 23; i++) send(v1[i], i == 22);
        step();
        check("t6_b2last_err", load_err, 1);
        rd(2'd0, 4'd0, 16'h0001, "t6_b2last_w1_0");
        full_load(v1, 0, 1'b0, 32'h1F);
        check("t6_good_swap", swap_pulse, 1);
        step();
        check("t6_good_err", load_err, 0);
        rd(2'd0, 4'd0, 16'h001A, "t6_good_w1_0");
`endif

        // Test 5: reset mid-load
        start_load();
        for (int i = 0; i < 5; i++) send(v4[i], 1'b0);
        rst_n = 1'b0;
        step();
        check("t5_ready", ld_ready, 0);
        check("t5_busy", load_busy, 0);
        check("t5_pvalid", params_valid, 0);
        check("t5_rd_data", rd_data, 0);
        rst_n = 1'b1;
        step();
        full_load(v1, 0, 1'b0, -1);
        check("t5_reload_pvalid", params_valid, 1);
        rd(2'd2, 4'd0, 16'h0005, "t5_b1_0");
        rd(2'd1, 4'd1, 16'h002C, "t5_w2_1");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
